ac97_frame_rx: RTL
==================

AC97_FRAME_RX -- requirements
Module: ac97_frame_rx

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; SHALL be at least 4x bit_clk frequency.
REQ-003 global_reset  in  1  synchronous, active-high reset.
REQ-004 bit_clk  in  1  12.288 MHz codec bit clock, asynchronous to clk.
REQ-005 sync  in  1  frame sync driven toward the codec, sampled here for frame alignment.
REQ-006 sdata_in  in  1  codec serial data, MSB first.
REQ-007 pcm_ack  in  1  consumer accepts left_in/right_in.
REQ-008 codec_ready  out  1  tag bit 15 of the last complete frame.
REQ-009 status_addr  out  7  slot1 bits [18:12].
REQ-010 status_data  out  16  slot2 bits [19:4].
REQ-011 status_valid  out  1  one-clk pulse on a new status readback.
REQ-012 left_in, right_in  out  20 each  captured slot3 and slot4 PCM.
REQ-013 pcm_valid  out  1  held high until acknowledged.
REQ-014 overrun  out  1  sticky: PCM frame dropped.
REQ-015 sync_err  out  1  sticky: sync edge arrived mid-frame.

Function
REQ-016 bit_clk, sync and sdata_in SHALL each pass through identical 2-FF synchronizers so all three see equal delay.
REQ-017 Sample strobe: one clk pulse on each falling edge of synchronized bit_clk (1->0 transition); all sampling SHALL occur only on the strobe.
REQ-018 FSM states: HUNT and RECEIVE; 8-bit bit counter bit_idx.
REQ-019 HUNT: on a strobe where sync_s=1 and the previous strobe's sync_s=0, go to RECEIVE with bit_idx=0, shift in that bit.
REQ-020 RECEIVE: each strobe shifts sdata_s into the current slot register and increments bit_idx; bit_idx wraps 255->0.
REQ-021 Slot map (bit_idx): tag 0-15, slot1 16-35, slot2 36-55, slot3 56-75, slot4 76-95; bits 96-255 are ignored.
REQ-022 Tag decoding: bit 15 = codec ready, bits 14/13/12/11 = valid for slots 1/2/3/4.
REQ-023 Frame completion is the strobe sampling bit_idx 255 (cycle N); all outputs update in cycle N+1.
REQ-024 After completion, a sync rising edge on the next strobe continues RECEIVE at bit 0; otherwise FSM returns to HUNT.
REQ-025 A sync rising edge at bit_idx != 0 in RECEIVE: discard the partial frame, set sync_err, restart at bit 0.
REQ-026 codec_ready SHALL update every completed frame.
REQ-027 status_addr/status_data load and status_valid pulses only if codec ready, slot1 valid and slot2 valid are all set.
REQ-028 PCM loads only if codec ready, slot3 valid and slot4 valid are all set.
REQ-029 PCM load with pcm_valid=0: load left_in/right_in and set pcm_valid.
REQ-030 PCM load with pcm_valid=1 and pcm_ack=0: drop the new data, keep the old data, set overrun.
REQ-031 PCM load coincident with pcm_ack=1: load the new data, pcm_valid stays 1, no overrun.
REQ-032 pcm_ack with no load and pcm_valid=1: clear pcm_valid next cycle; pcm_ack with pcm_valid=0 is ignored.
REQ-033 sync_err and overrun SHALL clear only on reset.

Reset
REQ-034 global_reset (synchronous, has priority over everything) SHALL set: FSM HUNT, bit_idx 0, all synchronizers 0, all outputs 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; the first frame accepted after reset requires a fresh sync rising edge.

Structure
REQ-036 Package ac97_pkg SHALL hold FRAME_BITS=256, the slot start/end indices, the tag bit positions and the FSM state enum.
REQ-037 One sub-module, sync_2ff, instantiated three times.
REQ-038 The block runs on the system clock next to the existing transmit path; it SHALL drive no codec pins.

Verification
REQ-039 Frame with tag 0xF800, slot1 addr 0x26, slot2 data 0x000F -> status_valid one pulse, status_addr=0x26, status_data=0x000F, codec_ready=1.
REQ-040 Frame with tag 0x9800, left 0x12345, right 0xABCDE -> pcm_valid=1 with left_in=0x12345, right_in=0xABCDE; pcm_ack -> pcm_valid=0 next cycle.
REQ-041 Two PCM frames, no ack -> first frame's data retained, overrun=1; repeat with pcm_ack on the load cycle -> second frame's data loaded, overrun stays 0.
REQ-042 Sync pulse injected at bit 100 -> sync_err=1, no status_valid or pcm_valid from the partial frame, next full frame captured correctly.
REQ-043 global_reset asserted at bit 60 -> all outputs 0; data resumes only after the next sync edge.
REQ-044 Tag 0x7800 (codec not ready) -> codec_ready=0, no status_valid, no pcm_valid.

Source files
------------

// File: rtl/ac97_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac97_pkg
//  Description : AC'97 input-frame geometry, tag bit positions and receiver
//                FSM state encoding shared by the frame receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int BIT_IDX_W  = 8;
    localparam int SLOT_W     = 20;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(FRAME_BITS - 1);

    // Slot boundaries, expressed as bit_idx positions within the frame
    localparam logic [7:0] TAG_START   = 8'd0;
    localparam logic [7:0] TAG_END     = 8'd15;
    localparam logic [7:0] SLOT1_START = 8'd16;
    localparam logic [7:0] SLOT1_END   = 8'd35;
    localparam logic [7:0] SLOT2_START = 8'd36;
    localparam logic [7:0] SLOT2_END   = 8'd55;
    localparam logic [7:0] SLOT3_START = 8'd56;
    localparam logic [7:0] SLOT3_END   = 8'd75;
    localparam logic [7:0] SLOT4_START = 8'd76;
    localparam logic [7:0] SLOT4_END   = 8'd95;

    // Tag bit positions
    localparam int TAG_READY_BIT  = 15;
    localparam int TAG_SLOT1_BIT  = 14;
    localparam int TAG_SLOT2_BIT  = 13;
    localparam int TAG_SLOT3_BIT  = 12;
    localparam int TAG_SLOT4_BIT  = 11;
    localparam int TAG_FLAG_LSB   = 11;
    localparam int TAG_FLAG_W     = TAG_READY_BIT - TAG_FLAG_LSB + 1;

    // Only the used sub-fields are captured: tag[15:11], slot1[18:12], slot2[19:4]
    localparam logic [7:0] TAG_FLAG_IDX_HI = TAG_END - 8'(TAG_FLAG_LSB);
    localparam logic [7:0] ADDR_IDX_LO     = SLOT1_START + 8'd1;
    localparam logic [7:0] ADDR_IDX_HI     = SLOT1_END - 8'd12;
    localparam logic [7:0] DATA_IDX_HI     = SLOT2_END - 8'd4;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_RECEIVE = 1'b1
    } rx_state_e;

    function automatic logic in_range(input logic [7:0] idx,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (idx >= lo) && (idx <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop single-bit synchronizer with synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ac97_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ac97_frame_rx
//  Description : AC'97 codec input-frame receiver: aligns to sync, decodes the
//                tag, captures status readback and slot3/slot4 PCM samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac97_frame_rx
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        global_reset,
    input  logic        bit_clk,
    input  logic        sync,
    input  logic        sdata_in,
    input  logic        pcm_ack,
    output logic        codec_ready,
    output logic [6:0]  status_addr,
    output logic [15:0] status_data,
    output logic        status_valid,
    output logic [19:0] left_in,
    output logic [19:0] right_in,
    output logic        pcm_valid,
    output logic        overrun,
    output logic        sync_err
);

    logic w_bclk_s;
    logic w_sync_s;
    logic w_sdata_s;

    sync_2ff u_sync_bclk  (.clk(clk), .rst(global_reset), .i_d(bit_clk),  .o_q(w_bclk_s));
    sync_2ff u_sync_sync  (.clk(clk), .rst(global_reset), .i_d(sync),     .o_q(w_sync_s));
    sync_2ff u_sync_sdata (.clk(clk), .rst(global_reset), .i_d(sdata_in), .o_q(w_sdata_s));

    logic r_bclk_prev;
    logic r_sync_last;
    logic w_strobe;
    logic w_sync_rise;

    assign w_strobe    = r_bclk_prev & ~w_bclk_s;
    assign w_sync_rise = w_sync_s & ~r_sync_last;

    // r_sync_last resets high so a sync held high through reset is not an edge
    always_ff @(posedge clk) begin
        if (global_reset) begin
            r_bclk_prev <= 1'b0;
            r_sync_last <= 1'b1;
        end else begin
            r_bclk_prev <= w_bclk_s;
            if (w_strobe) begin
                r_sync_last <= w_sync_s;
            end
        end
    end

    rx_state_e              r_state;
    rx_state_e              w_state_next;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BIT_IDX_W-1:0]   w_bit_idx_next;
    logic                   w_shift_en;
    logic [BIT_IDX_W-1:0]   w_shift_idx;
    logic                   w_frame_done;
    logic                   w_sync_err_set;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            r_state   <= ST_HUNT;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_shift_en     = 1'b0;
        w_shift_idx    = r_bit_idx;
        w_frame_done   = 1'b0;
        w_sync_err_set = 1'b0;
        if (w_strobe) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_sync_rise) begin
                        w_state_next   = ST_RECEIVE;
                        w_shift_en     = 1'b1;
                        w_shift_idx    = '0;
                        w_bit_idx_next = BIT_IDX_W'(1);
                    end
                end
                ST_RECEIVE: begin
                    if (w_sync_rise) begin
                        // Any sync edge restarts at bit 0; off-boundary ones are errors
                        w_shift_en     = 1'b1;
                        w_shift_idx    = '0;
                        w_bit_idx_next = BIT_IDX_W'(1);
                        w_sync_err_set = (r_bit_idx != '0);
                    end else if (r_bit_idx == '0) begin
                        w_state_next   = ST_HUNT;
                    end else begin
                        w_shift_en     = 1'b1;
                        w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
                        w_frame_done   = (r_bit_idx == LAST_BIT_IDX);
                    end
                end
            endcase
        end
    end

    logic [TAG_FLAG_W-1:0] r_tag_flags;
    logic [6:0]            r_addr_sr;
    logic [15:0]           r_data_sr;
    logic [SLOT_W-1:0]     r_slot3_sr;
    logic [SLOT_W-1:0]     r_slot4_sr;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            r_tag_flags <= '0;
            r_addr_sr   <= '0;
            r_data_sr   <= '0;
            r_slot3_sr  <= '0;
            r_slot4_sr  <= '0;
        end else if (w_shift_en) begin
            if (in_range(w_shift_idx, TAG_START, TAG_FLAG_IDX_HI))
                r_tag_flags <= {r_tag_flags[TAG_FLAG_W-2:0], w_sdata_s};
            if (in_range(w_shift_idx, ADDR_IDX_LO, ADDR_IDX_HI))
                r_addr_sr   <= {r_addr_sr[5:0], w_sdata_s};
            if (in_range(w_shift_idx, SLOT2_START, DATA_IDX_HI))
                r_data_sr   <= {r_data_sr[14:0], w_sdata_s};
            if (in_range(w_shift_idx, SLOT3_START, SLOT3_END))
                r_slot3_sr  <= {r_slot3_sr[SLOT_W-2:0], w_sdata_s};
            if (in_range(w_shift_idx, SLOT4_START, SLOT4_END))
                r_slot4_sr  <= {r_slot4_sr[SLOT_W-2:0], w_sdata_s};
        end
    end

    logic w_ready;
    logic w_status_load;
    logic w_pcm_load;

    assign w_ready       = r_tag_flags[TAG_READY_BIT - TAG_FLAG_LSB];
    assign w_status_load = w_frame_done & w_ready
                         & r_tag_flags[TAG_SLOT1_BIT - TAG_FLAG_LSB]
                         & r_tag_flags[TAG_SLOT2_BIT - TAG_FLAG_LSB];
    assign w_pcm_load    = w_frame_done & w_ready
                         & r_tag_flags[TAG_SLOT3_BIT - TAG_FLAG_LSB]
                         & r_tag_flags[TAG_SLOT4_BIT - TAG_FLAG_LSB];

    logic        r_codec_ready;
    logic [6:0]  r_status_addr;
    logic [15:0] r_status_data;
    logic        r_status_valid;
    logic [19:0] r_left;
    logic [19:0] r_right;
    logic        r_pcm_valid;
    logic        r_overrun;
    logic        r_sync_err;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            r_codec_ready  <= 1'b0;
            r_status_addr  <= '0;
            r_status_data  <= '0;
            r_status_valid <= 1'b0;
            r_left         <= '0;
            r_right        <= '0;
            r_pcm_valid    <= 1'b0;
            r_overrun      <= 1'b0;
            r_sync_err     <= 1'b0;
        end else begin
            r_status_valid <= 1'b0;
            if (w_sync_err_set)
                r_sync_err <= 1'b1;
            if (w_frame_done)
                r_codec_ready <= w_ready;
            if (w_status_load) begin
                r_status_addr  <= r_addr_sr;
                r_status_data  <= r_data_sr;
                r_status_valid <= 1'b1;
            end
            // A consumer ack in the load cycle frees the buffer for the new sample
            if (w_pcm_load) begin
                if (!r_pcm_valid || pcm_ack) begin
                    r_left      <= r_slot3_sr;
                    r_right     <= r_slot4_sr;
                    r_pcm_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (pcm_ack) begin
                r_pcm_valid <= 1'b0;
            end
        end
    end

    assign codec_ready  = r_codec_ready;
    assign status_addr  = r_status_addr;
    assign status_data  = r_status_data;
    assign status_valid = r_status_valid;
    assign left_in      = r_left;
    assign right_in     = r_right;
    assign pcm_valid    = r_pcm_valid;
    assign overrun      = r_overrun;
    assign sync_err     = r_sync_err;

endmodule
`default_nettype wire
